// File: rtl/logic_clock_domain_crossing_multi_pointer_sync.sv
// rtl/logic_clock_domain_crossing_multi_pointer_sync.sv - multi-channel gray pointer synchroniser with delta, strobe and gray check
//
// Destination-side receiver for CHANNELS independent gray-coded pointers
// launched from foreign clock domains. Per channel: STAGES-deep bit
// synchroniser into aclk, gray-to-binary conversion, registered binary
// pointer, registered advance (delta) and update strobe, and an optional
// sticky detector of illegal multi-bit gray steps.
//
// Optional feature macro: LOGIC_CLOCK_DOMAIN_CROSSING_GRAY_CHECK_EN
//   defined   : gray history + Hamming checker built, gray_error is sticky
//   undefined : gray_error tied to 0, gray_error_clear ignored
//
// Ports:
//   aclk             in   destination clock, all state on posedge
//   areset           in   synchronous active-high reset
//   gray_pointer     in   CHANNELS*ADDRESS_WIDTH source-registered gray pointers
//   gray_error_clear in   CHANNELS per-channel clear of sticky gray_error
//   pointer_synced   out  CHANNELS*ADDRESS_WIDTH synchronised binary pointers
//   pointer_delta    out  CHANNELS*ADDRESS_WIDTH advance since previous cycle
//   pointer_updated  out  CHANNELS one-cycle change strobe
//   gray_error       out  CHANNELS sticky illegal-transition flag

package logic_pkg;
    typedef enum logic [1:0] {
        TARGET_GENERIC = 2'd0,
        TARGET_XILINX  = 2'd1,
        TARGET_INTEL   = 2'd2
    } target_e;
endpackage

module logic_clock_domain_crossing_multi_pointer_sync #(
    parameter int               CHANNELS      = 1,
    parameter int               ADDRESS_WIDTH = 4,
    parameter int               STAGES        = 2,
    parameter logic_pkg::target_e TARGET      = logic_pkg::TARGET_GENERIC
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [CHANNELS*ADDRESS_WIDTH-1:0]   gray_pointer,
    input  logic [CHANNELS-1:0]                 gray_error_clear,
    output logic [CHANNELS*ADDRESS_WIDTH-1:0]   pointer_synced,
    output logic [CHANNELS*ADDRESS_WIDTH-1:0]   pointer_delta,
    output logic [CHANNELS-1:0]                 pointer_updated,
    output logic [CHANNELS-1:0]                 gray_error
);

    localparam int W = ADDRESS_WIDTH;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set (Hamming distance > 1 on an xor).
    function automatic logic multi_bit(input logic [W-1:0] d);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        return multi;
    endfunction

`ifndef LOGIC_CLOCK_DOMAIN_CROSSING_GRAY_CHECK_EN
    logic unused_gray_error_clear;
    assign unused_gray_error_clear = ^gray_error_clear;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [W-1:0]              stage1;
        logic [STAGES-2:0][W-1:0]  tail_q;
        logic [W-1:0]              gray_last;
        logic [W-1:0]              bin_d;
        logic [W-1:0]              ptr_q;
        logic [W-1:0]              delta_q;
        logic                      upd_q;

        // Stage 1 is the only flop that can go metastable; it carries the
        // target-specific synchroniser tag so timing tools treat it as such.
        if (TARGET == logic_pkg::TARGET_XILINX) begin : g_meta_xilinx
            (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta_q;
            always_ff @(posedge aclk) begin
                if (areset) begin
                    meta_q <= '0;
                end else begin
                    meta_q <= gray_pointer[c*W +: W];
                end
            end
            assign stage1 = meta_q;
        end else if (TARGET == logic_pkg::TARGET_INTEL) begin : g_meta_intel
            (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *) logic [W-1:0] meta_q;
            always_ff @(posedge aclk) begin
                if (areset) begin
                    meta_q <= '0;
                end else begin
                    meta_q <= gray_pointer[c*W +: W];
                end
            end
            assign stage1 = meta_q;
        end else begin : g_meta_generic
            (* async_reg = "true" *) logic [W-1:0] meta_q;
            always_ff @(posedge aclk) begin
                if (areset) begin
                    meta_q <= '0;
                end else begin
                    meta_q <= gray_pointer[c*W +: W];
                end
            end
            assign stage1 = meta_q;
        end

        // Remaining synchroniser stages: plain shift, no logic in between.
        always_ff @(posedge aclk) begin
            if (areset) begin
                tail_q <= '0;
            end else begin
                tail_q[0] <= stage1;
                for (int s = 1; s < STAGES - 1; s++) begin
                    tail_q[s] <= tail_q[s-1];
                end
            end
        end

        assign gray_last = tail_q[STAGES-2];
        assign bin_d     = gray2bin(gray_last);

        // Delta and strobe are computed against the current output so they
        // line up with the cycle in which the new pointer becomes visible.
        always_ff @(posedge aclk) begin
            if (areset) begin
                ptr_q   <= '0;
                delta_q <= '0;
                upd_q   <= 1'b0;
            end else begin
                ptr_q   <= bin_d;
                delta_q <= bin_d - ptr_q;
                upd_q   <= (bin_d != ptr_q);
            end
        end

        assign pointer_synced[c*W +: W] = ptr_q;
        assign pointer_delta[c*W +: W]  = delta_q;
        assign pointer_updated[c]       = upd_q;

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_GRAY_CHECK_EN
        logic [W-1:0] hist_q;
        logic         err_q;
        logic         multi_step;

        assign multi_step = multi_bit(gray_last ^ hist_q);

        // Set has priority over clear so a violation coinciding with a
        // clear is never lost.
        always_ff @(posedge aclk) begin
            if (areset) begin
                hist_q <= '0;
                err_q  <= 1'b0;
            end else begin
                hist_q <= gray_last;
                err_q  <= multi_step | (err_q & ~gray_error_clear[c]);
            end
        end

        assign gray_error[c] = err_q;
`else
        assign gray_error[c] = 1'b0;
`endif
    end

endmodule
